dram_cmd_arbiter: RTL and testbench

//  Shares the single accelerator DRAM command/response port (io_dram_cmd_* / io_dram_resp_*)

---
 rtl/dram_cmd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dram_cmd_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_arbiter.sv
// ============================================================================
// Module  : dram_cmd_arbiter
// Brief   : Round-robin sharing of one DRAM command/response port among
//           NUM_STREAMS stream units, with per-stream read credit tracking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dram_cmd_arbiter #(
    parameter int NUM_STREAMS     = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int BURST_W         = 512
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_STREAMS-1:0]         req_valid,
    output logic [NUM_STREAMS-1:0]         req_ready,
    input  logic [NUM_STREAMS*32-1:0]      req_addr,
    input  logic [NUM_STREAMS-1:0]         req_isWr,
    input  logic [NUM_STREAMS*32-1:0]      req_tag,
    input  logic [NUM_STREAMS*BURST_W-1:0] req_wdata,
    output logic                           dram_cmd_valid,
    input  logic                           dram_cmd_ready,
    output logic [31:0]                    dram_cmd_addr,
    output logic                           dram_cmd_isWr,
    output logic [31:0]                    dram_cmd_tag,
    output logic [BURST_W-1:0]             dram_cmd_wdata,
    output logic [31:0]                    dram_cmd_streamId,
    input  logic                           dram_resp_valid,
    output logic                           dram_resp_ready,
    input  logic [31:0]                    dram_resp_streamId,
    input  logic [31:0]                    dram_resp_tag,
    input  logic [BURST_W-1:0]             dram_resp_rdata,
    output logic [NUM_STREAMS-1:0]         resp_valid,
    input  logic [NUM_STREAMS-1:0]         resp_ready,
    output logic [31:0]                    resp_tag,
    output logic [BURST_W-1:0]             resp_rdata,
    output logic                           err_bad_id
);

    localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic                 r_cmd_valid;
    logic [31:0]          r_cmd_addr;
    logic                 r_cmd_isWr;
    logic [31:0]          r_cmd_tag;
    logic [BURST_W-1:0]   r_cmd_wdata;
    logic [SW-1:0]        r_cmd_sid;
    logic [SW-1:0]        r_rr;
    logic [CW-1:0]        r_cnt [NUM_STREAMS];
    logic                 r_err;

    logic                 w_slot_free;
    logic [NUM_STREAMS-1:0] w_elig;
    logic                 w_gnt_any;
    logic [SW-1:0]        w_gnt_idx;
    logic [SW:0]          w_scan;
    logic [31:0]          w_g_addr;
    logic                 w_g_isWr;
    logic [31:0]          w_g_tag;
    logic [BURST_W-1:0]   w_g_wdata;
    logic                 w_id_ok;
    logic [SW-1:0]        w_id;
    logic                 w_resp_fire;
    logic [NUM_STREAMS-1:0] w_inc;
    logic [NUM_STREAMS-1:0] w_dec;

    // The slot may be refilled in the same cycle it is drained.
    assign w_slot_free = !r_cmd_valid || dram_cmd_ready;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            w_elig[i] = req_valid[i] && (req_isWr[i] || (r_cnt[i] < CW'(MAX_OUTSTANDING)));
        end
    end

    // Scan from the round-robin pointer, wrapping at NUM_STREAMS.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            w_scan = {1'b0, r_rr} + (SW+1)'(k);
            if (w_scan >= (SW+1)'(NUM_STREAMS)) begin
                w_scan = w_scan - (SW+1)'(NUM_STREAMS);
            end
            if (!w_gnt_any && w_slot_free && !reset && w_elig[w_scan[SW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan[SW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_g_addr  = '0;
        w_g_isWr  = 1'b0;
        w_g_tag   = '0;
        w_g_wdata = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (w_gnt_idx == SW'(i)) begin
                req_ready[i] = w_gnt_any;
                w_g_addr     = req_addr[32*i +: 32];
                w_g_isWr     = req_isWr[i];
                w_g_tag      = req_tag[32*i +: 32];
                w_g_wdata    = req_wdata[BURST_W*i +: BURST_W];
            end
        end
    end

    // Response routing; out-of-range ids are accepted and discarded.
    assign w_id_ok         = dram_resp_streamId < 32'(NUM_STREAMS);
    assign w_id            = dram_resp_streamId[SW-1:0];
    assign dram_resp_ready = w_id_ok ? resp_ready[w_id] : 1'b1;
    assign w_resp_fire     = dram_resp_valid && dram_resp_ready;
    assign resp_tag        = dram_resp_tag;
    assign resp_rdata      = dram_resp_rdata;

    always_comb begin
        resp_valid = '0;
        w_inc      = '0;
        w_dec      = '0;
        if (w_id_ok) begin
            resp_valid[w_id] = dram_resp_valid;
        end
        for (int i = 0; i < NUM_STREAMS; i++) begin
            w_inc[i] = w_gnt_any && (w_gnt_idx == SW'(i)) && !req_isWr[i];
            w_dec[i] = w_resp_fire && w_id_ok && (w_id == SW'(i)) && (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_isWr  <= 1'b0;
            r_cmd_tag   <= '0;
            r_cmd_wdata <= '0;
            r_cmd_sid   <= '0;
            r_rr        <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= w_g_addr;
                r_cmd_isWr  <= w_g_isWr;
                r_cmd_tag   <= w_g_tag;
                r_cmd_wdata <= w_g_wdata;
                r_cmd_sid   <= w_gnt_idx;
                r_rr        <= (w_gnt_idx == SW'(NUM_STREAMS-1)) ? '0 : w_gnt_idx + SW'(1);
            end else if (dram_cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
            if (dram_resp_valid && !w_id_ok) begin
                r_err <= 1'b1;
            end
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

    assign dram_cmd_valid    = r_cmd_valid;
    assign dram_cmd_addr     = r_cmd_addr;
    assign dram_cmd_isWr     = r_cmd_isWr;
    assign dram_cmd_tag      = r_cmd_tag;
    assign dram_cmd_wdata    = r_cmd_wdata;
    assign dram_cmd_streamId = 32'(r_cmd_sid);
    assign err_bad_id        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dram_cmd_arbiter.sv
// ============================================================================
// Module  : tb_dram_cmd_arbiter
// Brief   : Directed, table-driven bench for dram_cmd_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dram_cmd_arbiter;

    localparam int N  = 4;
    localparam int BW = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_ready, req_isWr, resp_valid, resp_ready;
    logic [N*32-1:0]   req_addr, req_tag;
    logic [N*BW-1:0]   req_wdata;
    logic              dram_cmd_valid, dram_cmd_ready, dram_cmd_isWr;
    logic [31:0]       dram_cmd_addr, dram_cmd_tag, dram_cmd_streamId;
    logic [BW-1:0]     dram_cmd_wdata;
    logic              dram_resp_valid, dram_resp_ready;
    logic [31:0]       dram_resp_streamId, dram_resp_tag, resp_tag;
    logic [BW-1:0]     dram_resp_rdata, resp_rdata;
    logic              err_bad_id;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dram_cmd_arbiter #(.NUM_STREAMS(N), .MAX_OUTSTANDING(8), .BURST_W(BW)) dut (
        .clock(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_isWr(req_isWr), .req_tag(req_tag), .req_wdata(req_wdata),
        .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ready(dram_cmd_ready),
        .dram_cmd_addr(dram_cmd_addr), .dram_cmd_isWr(dram_cmd_isWr),
        .dram_cmd_tag(dram_cmd_tag), .dram_cmd_wdata(dram_cmd_wdata),
        .dram_cmd_streamId(dram_cmd_streamId),
        .dram_resp_valid(dram_resp_valid), .dram_resp_ready(dram_resp_ready),
        .dram_resp_streamId(dram_resp_streamId), .dram_resp_tag(dram_resp_tag),
        .dram_resp_rdata(dram_resp_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_tag(resp_tag), .resp_rdata(resp_rdata), .err_bad_id(err_bad_id)
    );

    typedef struct {
        logic [N-1:0] rv;
        logic [N-1:0] wr;
        logic         cr;
        logic         pv;
        logic [31:0]  pid;
        logic [N-1:0] prdy;
        logic [N-1:0] e_rr;
        logic         e_cv;
        logic [31:0]  e_sid;
        logic [N-1:0] e_pv;
        logic         e_prdy;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(logic [N-1:0] rv, logic [N-1:0] wr, logic cr, logic pv,
                                logic [31:0] pid, logic [N-1:0] prdy, logic [N-1:0] e_rr,
                                logic e_cv, logic [31:0] e_sid, logic [N-1:0] e_pv,
                                logic e_prdy);
        vec_t v;
        v.rv = rv; v.wr = wr; v.cr = cr; v.pv = pv; v.pid = pid; v.prdy = prdy;
        v.e_rr = e_rr; v.e_cv = e_cv; v.e_sid = e_sid; v.e_pv = e_pv; v.e_prdy = e_prdy;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] tag_of(int i);
        return 32'h0000_0100 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic default_fields();
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            w = 32'hD000_0000 + 32'(i);
            req_addr[32*i +: 32] = addr_of(i);
            req_tag[32*i +: 32]  = tag_of(i);
            req_wdata[BW*i +: BW] = {16{w}};
        end
    endtask

    initial begin
        int grants;
        reset = 1'b1;
        req_valid = '0; req_isWr = '0; resp_ready = '1;
        default_fields();
        dram_cmd_ready = 1'b1;
        dram_resp_valid = 1'b0; dram_resp_streamId = '0;
        dram_resp_tag = '0; dram_resp_rdata = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #4;
        chk("reset cmd_valid", BW'(dram_cmd_valid), '0);
        chk("reset cmd_addr", BW'(dram_cmd_addr), '0);
        chk("reset cmd_tag", BW'(dram_cmd_tag), '0);
        chk("reset cmd_isWr", BW'(dram_cmd_isWr), '0);
        chk("reset cmd_wdata", dram_cmd_wdata, '0);
        chk("reset cmd_streamId", BW'(dram_cmd_streamId), '0);
        chk("reset err_bad_id", BW'(err_bad_id), '0);
        chk("reset req_ready", BW'(req_ready), '0);
        chk("reset resp_valid", BW'(resp_valid), '0);
        tick();

        // Fairness, backpressure hold, wrap-around and response routing.
        vecs[0]  = mk(4'b1111, 4'b1111, 1, 0, 0, 4'b1111, 4'b0001, 0, 0, 4'b0000, 1);
        vecs[1]  = mk(4'b1111, 4'b1111, 1, 0, 0, 4'b1111, 4'b0010, 1, 0, 4'b0000, 1);
        vecs[2]  = mk(4'b1111, 4'b1111, 1, 0, 0, 4'b1111, 4'b0100, 1, 1, 4'b0000, 1);
        vecs[3]  = mk(4'b1111, 4'b1111, 1, 0, 0, 4'b1111, 4'b1000, 1, 2, 4'b0000, 1);
        vecs[4]  = mk(4'b1111, 4'b1111, 1, 0, 0, 4'b1111, 4'b0001, 1, 3, 4'b0000, 1);
        vecs[5]  = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1);
        vecs[6]  = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1);
        vecs[7]  = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1);
        vecs[8]  = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1);
        vecs[9]  = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1);
        vecs[10] = mk(4'b1111, 4'b1111, 1, 0, 0, 4'b1111, 4'b0010, 1, 0, 4'b0000, 1);
        vecs[11] = mk(4'b0000, 4'b1111, 1, 0, 2, 4'b1111, 4'b0000, 1, 1, 4'b0000, 1);
        vecs[12] = mk(4'b1010, 4'b1111, 1, 0, 0, 4'b1111, 4'b1000, 0, 0, 4'b0000, 1);
        vecs[13] = mk(4'b1010, 4'b1111, 1, 0, 0, 4'b1111, 4'b0010, 1, 3, 4'b0000, 1);
        vecs[14] = mk(4'b0000, 4'b1111, 1, 1, 3, 4'b1111, 4'b0000, 1, 1, 4'b1000, 1);
        vecs[15] = mk(4'b0000, 4'b1111, 1, 1, 1, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0);

        for (int r = 0; r < 16; r++) begin
            req_valid = vecs[r].rv; req_isWr = vecs[r].wr; dram_cmd_ready = vecs[r].cr;
            dram_resp_valid = vecs[r].pv; dram_resp_streamId = vecs[r].pid;
            resp_ready = vecs[r].prdy;
            #4;
            chk($sformatf("row%0d req_ready", r), BW'(req_ready), BW'(vecs[r].e_rr));
            chk($sformatf("row%0d cmd_valid", r), BW'(dram_cmd_valid), BW'(vecs[r].e_cv));
            if (vecs[r].e_cv) begin
                chk($sformatf("row%0d cmd_streamId", r), BW'(dram_cmd_streamId), BW'(vecs[r].e_sid));
                chk($sformatf("row%0d cmd_addr", r), BW'(dram_cmd_addr), BW'(addr_of(int'(vecs[r].e_sid))));
            end
            chk($sformatf("row%0d resp_valid", r), BW'(resp_valid), BW'(vecs[r].e_pv));
            chk($sformatf("row%0d dram_resp_ready", r), BW'(dram_resp_ready), BW'(vecs[r].e_prdy));
            tick();
        end
        dram_resp_valid = 1'b0; resp_ready = '1; req_valid = '0; dram_cmd_ready = 1'b1;

        // Single read from stream 2 and its routed response.
        req_addr[64 +: 32] = 32'h0000_1000; req_tag[64 +: 32] = 32'd5;
        req_valid = 4'b0100; req_isWr = 4'b0000;
        #4 chk("t1 req_ready", BW'(req_ready), BW'(4'b0100));
        tick();
        req_valid = '0;
        dram_resp_valid = 1'b1; dram_resp_streamId = 2; dram_resp_tag = 5;
        dram_resp_rdata = {16{32'hCAFE_0002}};
        #4;
        chk("t1 cmd_valid", BW'(dram_cmd_valid), BW'(1'b1));
        chk("t1 cmd_addr", BW'(dram_cmd_addr), BW'(32'h1000));
        chk("t1 cmd_streamId", BW'(dram_cmd_streamId), BW'(32'd2));
        chk("t1 cmd_isWr", BW'(dram_cmd_isWr), '0);
        chk("t1 cmd_tag", BW'(dram_cmd_tag), BW'(32'd5));
        chk("t1 resp_valid", BW'(resp_valid), BW'(4'b0100));
        chk("t1 resp_tag", BW'(resp_tag), BW'(32'd5));
        chk("t1 resp_rdata", resp_rdata, {16{32'hCAFE_0002}});
        chk("t1 dram_resp_ready", BW'(dram_resp_ready), BW'(1'b1));
        tick();
        dram_resp_valid = 1'b0;
        default_fields();

        // Credit limit on stream 0.
        req_valid = 4'b0001; req_isWr = '0;
        for (int k = 0; k < 8; k++) begin
            #4 chk($sformatf("t4 read%0d req_ready", k), BW'(req_ready), BW'(4'b0001));
            tick();
        end
        #4 chk("t4 ninth read stalls", BW'(req_ready), '0);
        tick();
        req_valid = 4'b0011;
        #4 chk("t4 stream1 granted", BW'(req_ready), BW'(4'b0010));
        tick();
        req_valid = 4'b0001;
        dram_resp_valid = 1'b1; dram_resp_streamId = 0;
        #4;
        chk("t4 still stalled", BW'(req_ready), '0);
        chk("t4 resp_valid", BW'(resp_valid), BW'(4'b0001));
        tick();
        dram_resp_valid = 1'b0;
        #4 chk("t4 credit returned", BW'(req_ready), BW'(4'b0001));
        tick();

        // Stream 1 issue and response in the same cycle leave its count at 1.
        req_valid = 4'b0010;
        dram_resp_valid = 1'b1; dram_resp_streamId = 1;
        #4;
        chk("t5 req_ready", BW'(req_ready), BW'(4'b0010));
        chk("t5 resp_valid", BW'(resp_valid), BW'(4'b0010));
        tick();
        dram_resp_valid = 1'b0;
        grants = 0;
        for (int k = 0; k < 10; k++) begin
            #4 if (req_ready[1]) grants++;
            tick();
        end
        chk("t5 remaining credits", BW'(grants), BW'(7));
        req_valid = '0;

        // Bad stream id.
        #4 chk("t6 err before", BW'(err_bad_id), '0);
        dram_resp_valid = 1'b1; dram_resp_streamId = 7;
        #1;
        chk("t6 dram_resp_ready", BW'(dram_resp_ready), BW'(1'b1));
        chk("t6 resp_valid", BW'(resp_valid), '0);
        tick();
        dram_resp_valid = 1'b0;
        repeat (3) tick();
        #4 chk("t6 err sticky", BW'(err_bad_id), BW'(1'b1));
        tick();

        // Reset while the slot holds a stalled command.
        req_valid = 4'b0100; req_isWr = 4'b0100; dram_cmd_ready = 1'b0;
        #4 chk("t6 write granted", BW'(req_ready), BW'(4'b0100));
        tick();
        #4;
        chk("t6 slot full", BW'(dram_cmd_valid), BW'(1'b1));
        chk("t6 slot isWr", BW'(dram_cmd_isWr), BW'(1'b1));
        reset = 1'b1;
        #1 chk("t6 req_ready in reset", BW'(req_ready), '0);
        tick();
        reset = 1'b0; req_valid = '0; dram_cmd_ready = 1'b1;
        #4;
        chk("t6 flushed cmd_valid", BW'(dram_cmd_valid), '0);
        chk("t6 flushed cmd_addr", BW'(dram_cmd_addr), '0);
        chk("t6 err cleared", BW'(err_bad_id), '0);
        req_valid = 4'b1010; req_isWr = 4'b1111;
        #1 chk("t6 rr pointer cleared", BW'(req_ready), BW'(4'b0010));
        tick();
        req_valid = 4'b0001; req_isWr = '0;
        #4 chk("t6 counters cleared", BW'(req_ready), BW'(4'b0001));
        tick();
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
